layer_sequencer: RTL and testbench

//   Parametrised frame sequencer for an N-layer conv1d network. On each rising edge of

---
 rtl/layer_sequencer.sv | 175 +++++++++++++++++
 tb/tb_layer_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Frame sequencer for an N-layer conv1d network.
// Steps shift buffers, runs each layer, latches scaled outputs.
module layer_sequencer #(
    parameter int W            = 16,
    parameter int D            = 8,
    parameter int NUM_LAYERS   = 2,
    parameter int OUT_CH       = 4,
    parameter int OUT_SHIFT    = 2,
    parameter int SATURATE     = 1,
    parameter int OVERRUN_MODE = 0,
    parameter int TIMEOUT      = 1023,
    parameter int CW           = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_clk,
    output logic                  lsb_clk,
    output logic [NUM_LAYERS-1:0] conv_rst,
    input  logic [NUM_LAYERS-1:0] conv_out_v,
    output logic [((NUM_LAYERS > 1) ? NUM_LAYERS - 1 : 1)-1:0] cache_clk,
    input  logic [D*W-1:0]        final_out,
    output logic [OUT_CH*W-1:0]   sample_out,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  timeout_flag,
    output logic [7:0]            overrun_count,
    output logic [CW-1:0]         cycles_last
);

    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int XW = W + OUT_SHIFT;
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CONV_RST,
        CONV_WAIT,
        CACHE_CLK,
        LATCH_OUT
    } state_t;

    state_t            state, state_n;
    logic [LW-1:0]     layer, layer_n;
    logic [31:0]       wait_cnt;
    logic [CW-1:0]     cyc_cnt, cyc_inc;
    logic              prev, rise, busy_edge;
    logic              tmo_hit, tmo_set, last_layer;
    logic [OUT_CH*W-1:0] sat_out;
    logic signed [W-1:0]  el;
    logic signed [XW-1:0] wide;
    logic [OUT_SHIFT:0]   hi;
    logic                 unused_bits;

    assign unused_bits = ^final_out;

    // Edge detector history, tracked even while in reset.
    always_ff @(posedge clk) begin
        prev <= sample_clk;
    end

    assign rise       = sample_clk & ~prev;
    assign busy       = (state != IDLE);
    assign busy_edge  = rise && (state != IDLE) && (state != LATCH_OUT);
    assign last_layer = (layer == LW'(NUM_LAYERS - 1));
    assign tmo_hit    = (TIMEOUT != 0) && (wait_cnt == 32'(TIMEOUT - 1));
    assign cyc_inc    = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CW'(1);

    // Next-state and layer index selection.
    always_comb begin
        state_n = state;
        layer_n = layer;
        tmo_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) state_n = SHIFT_IN;
            end
            SHIFT_IN: begin
                state_n = CONV_RST;
                layer_n = '0;
            end
            CONV_RST: state_n = CONV_WAIT;
            CONV_WAIT: begin
                if (conv_out_v[layer]) begin
                    state_n = last_layer ? LATCH_OUT : CACHE_CLK;
                end else if (tmo_hit) begin
                    tmo_set = 1'b1;
                    state_n = IDLE;
                end
            end
            CACHE_CLK: begin
                state_n = CONV_RST;
                layer_n = layer + LW'(1);
            end
            LATCH_OUT: state_n = rise ? SHIFT_IN : IDLE;
            default:   state_n = IDLE;
        endcase
        if (busy_edge && OVERRUN_MODE == 0) begin
            state_n = SHIFT_IN;
            layer_n = '0;
        end
    end

    // Moore strobe decodes of the state register.
    always_comb begin
        lsb_clk   = (state == SHIFT_IN);
        conv_rst  = '0;
        cache_clk = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            conv_rst[k] = (state == CONV_RST) && (layer == LW'(k));
        end
        for (int k = 0; k < NUM_LAYERS - 1; k++) begin
            cache_clk[k] = (state == CACHE_CLK) && (layer == LW'(k));
        end
    end

    // Scale each channel and clamp or wrap to W bits.
    always_comb begin
        sat_out = '0;
        el      = '0;
        wide    = '0;
        hi      = '0;
        for (int c = 0; c < OUT_CH; c++) begin
            el   = final_out[(D-1-c)*W +: W];
            wide = XW'(el) <<< OUT_SHIFT;
            hi   = wide[XW-1:W-1];
            if (SATURATE != 0 && !((&hi) || !(|hi))) begin
                sat_out[(OUT_CH-1-c)*W +: W] = wide[XW-1] ? SMIN : SMAX;
            end else begin
                sat_out[(OUT_CH-1-c)*W +: W] = wide[W-1:0];
            end
        end
    end

    // Sequencer state, counters and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            layer         <= '0;
            wait_cnt      <= '0;
            cyc_cnt       <= '0;
            sample_out    <= '0;
            frame_done    <= 1'b0;
            timeout_flag  <= 1'b0;
            overrun_count <= '0;
            cycles_last   <= '0;
        end else begin
            state      <= state_n;
            layer      <= layer_n;
            frame_done <= (state == LATCH_OUT);
            if (state == CONV_RST) begin
                wait_cnt <= '0;
            end else if (state == CONV_WAIT) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
            if (state == SHIFT_IN) begin
                cyc_cnt <= CW'(1);
            end else if (state != IDLE) begin
                cyc_cnt <= cyc_inc;
            end
            if (state == LATCH_OUT) begin
                sample_out  <= sat_out;
                cycles_last <= cyc_inc;
            end
            if (tmo_set) begin
                timeout_flag <= 1'b1;
            end
            if (busy_edge && overrun_count != 8'hFF) begin
                overrun_count <= overrun_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: two instances,
// saturating/restart (a) and wrapping/drop (b).
module tb_layer_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sample_clk = 1'b0;
    logic [127:0] final_out = '0;
    logic [1:0]   mask = 2'b11;
    logic [1:0]   force_v = 2'b00;

    logic         lsb_a, lsb_b, fd_a, fd_b, busy_a, busy_b;
    logic         tmo_a, tmo_b;
    logic [1:0]   crst_a, crst_b;
    logic [0:0]   cclk_a, cclk_b;
    logic [63:0]  so_a, so_b;
    logic [7:0]   ovr_a, ovr_b;
    logic [15:0]  cyc_a, cyc_b;
    logic [1:0]   vreg_a = '0, vreg_b = '0;
    logic [1:0]   cv_a, cv_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Conv model: valid one cycle after conv_rst, per-layer enable.
    always @(posedge clk) begin
        vreg_a <= crst_a & mask;
        vreg_b <= crst_b & mask;
    end
    assign cv_a = vreg_a | force_v;
    assign cv_b = vreg_b | force_v;

    layer_sequencer #(
        .OUT_SHIFT(2), .SATURATE(1), .OVERRUN_MODE(0), .TIMEOUT(8)
    ) dut_a (
        .clk(clk), .rst(rst), .sample_clk(sample_clk),
        .lsb_clk(lsb_a), .conv_rst(crst_a), .conv_out_v(cv_a),
        .cache_clk(cclk_a), .final_out(final_out),
        .sample_out(so_a), .frame_done(fd_a), .busy(busy_a),
        .timeout_flag(tmo_a), .overrun_count(ovr_a),
        .cycles_last(cyc_a)
    );

    layer_sequencer #(
        .OUT_SHIFT(2), .SATURATE(0), .OVERRUN_MODE(1), .TIMEOUT(8)
    ) dut_b (
        .clk(clk), .rst(rst), .sample_clk(sample_clk),
        .lsb_clk(lsb_b), .conv_rst(crst_b), .conv_out_v(cv_b),
        .cache_clk(cclk_b), .final_out(final_out),
        .sample_out(so_b), .frame_done(fd_b), .busy(busy_b),
        .timeout_flag(tmo_b), .overrun_count(ovr_b),
        .cycles_last(cyc_b)
    );

    typedef struct {
        logic [127:0] fo;
        logic [63:0]  exp_s;
        logic [63:0]  exp_t;
    } vec_t;

    vec_t vecs[4];

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic pulse_edge;
        sample_clk = 1'b1;
        tick();
        sample_clk = 1'b0;
    endtask

    task automatic count_fd(input int n, output int na, output int nb);
        na = 0;
        nb = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (fd_a) na++;
            if (fd_b) nb++;
        end
    endtask

    task automatic do_frame(output int na, output int nb);
        pulse_edge();
        count_fd(20, na, nb);
    endtask

    initial begin
        int na, nb, seen;
        logic [5:0] pat;
        logic [5:0] t1_exp [8];
        logic [63:0] keep_a, keep_b;

        vecs[0] = '{{16'h1000, 16'h3000, 16'hD000, 16'hFFFF,
                     16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0},
                    64'h4000_7FFF_8000_FFFC, 64'h4000_C000_4000_FFFC};
        vecs[1] = '{{16'h0001, 16'h1FFF, 16'hE000, 16'h7FFF,
                     16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
                    64'h0004_7FFC_8000_7FFF, 64'h0004_7FFC_8000_FFFC};
        vecs[2] = '{{16'h2000, 16'hDFFF, 16'h0000, 16'hFFFF,
                     16'h8000, 16'h8000, 16'h8000, 16'h8000},
                    64'h7FFF_8000_0000_FFFC, 64'h8000_7FFC_0000_FFFC};
        vecs[3] = '{{16'h8000, 16'h7FFF, 16'hC000, 16'h3FFF,
                     16'h0000, 16'h0000, 16'h0000, 16'h0000},
                    64'h8000_7FFF_8000_7FFF, 64'h0000_FFFC_0000_FFFC};

        // {busy, lsb, conv_rst0, cache0, conv_rst1, frame_done}
        t1_exp = '{6'b110000, 6'b101000, 6'b100000, 6'b100100,
                   6'b100010, 6'b100000, 6'b100000, 6'b000001};

        // Reset state
        repeat (3) tick();
        chk("rst_so", so_a, 64'h0);
        chk("rst_busy", {busy_a, busy_b}, 2'b00);
        chk("rst_strobes", {lsb_a, crst_a, cclk_a, fd_a}, 5'b0);
        chk("rst_status", {tmo_a, ovr_a, cyc_a}, 25'h0);
        rst = 1'b0;
        tick();

        // T1: strobe order and frame length
        final_out = vecs[0].fo;
        sample_clk = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            sample_clk = 1'b0;
            pat = {busy_a, lsb_a, crst_a[0], cclk_a[0], crst_a[1], fd_a};
            chk($sformatf("t1_cyc%0d", c + 1), pat, t1_exp[c]);
        end
        chk("t1_cycles", cyc_a, 16'd7);
        count_fd(6, na, nb);
        chk("t1_no_extra_done", na, 0);

        // T2: output scaling table
        foreach (vecs[i]) begin
            final_out = vecs[i].fo;
            do_frame(na, nb);
            chk($sformatf("t2_done_a%0d", i), na, 1);
            chk($sformatf("t2_done_b%0d", i), nb, 1);
            chk($sformatf("t2_sat%0d", i), so_a, vecs[i].exp_s);
            chk($sformatf("t2_trunc%0d", i), so_b, vecs[i].exp_t);
            chk($sformatf("t2_cyc%0d", i), cyc_a, 16'd7);
        end

        // T6: edge in the LATCH_OUT cycle
        pulse_edge();
        repeat (6) tick();
        sample_clk = 1'b1;
        tick();
        sample_clk = 1'b0;
        chk("t6_done_lsb_a", {fd_a, lsb_a}, 2'b11);
        chk("t6_done_lsb_b", {fd_b, lsb_b}, 2'b11);
        count_fd(20, na, nb);
        chk("t6_next_frame", {na[3:0], nb[3:0]}, 8'h11);
        chk("t6_no_overrun", {ovr_a, ovr_b}, 16'h0);

        // T3: edge during layer-1 CONV_WAIT
        mask = 2'b01;
        pulse_edge();
        repeat (5) tick();
        chk("t3_in_wait", {crst_a, cclk_a, lsb_a, busy_a}, 5'b00001);
        sample_clk = 1'b1;
        tick();
        sample_clk = 1'b0;
        chk("t3_restart_lsb_a", lsb_a, 1'b1);
        chk("t3_cont_b", {lsb_b, busy_b}, 2'b01);
        mask = 2'b11;
        force_v = 2'b10;
        tick();
        force_v = 2'b00;
        count_fd(20, na, nb);
        chk("t3_done_a", na, 1);
        chk("t3_done_b", nb, 1);
        chk("t3_ovr", {ovr_a, ovr_b}, 16'h0101);
        chk("t3_cyc_a", cyc_a, 16'd7);
        chk("t3_cyc_b", cyc_b, 16'd8);

        // T4: timeout on layer 0
        keep_a = so_a;
        keep_b = so_b;
        mask = 2'b10;
        pulse_edge();
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (fd_a || fd_b) seen++;
        end
        chk("t4_busy_last_wait", {busy_a, busy_b, tmo_a}, 3'b110);
        tick();
        chk("t4_idle", {busy_a, busy_b}, 2'b00);
        chk("t4_flag", {tmo_a, tmo_b}, 2'b11);
        chk("t4_no_done", seen, 0);
        chk("t4_so_a", so_a, keep_a);
        chk("t4_so_b", so_b, keep_b);
        chk("t4_cyc_kept", {cyc_a, cyc_b}, {16'd7, 16'd8});
        mask = 2'b11;
        do_frame(na, nb);
        chk("t4_recover", {na[3:0], nb[3:0]}, 8'h11);
        chk("t4_recover_cyc", cyc_a, 16'd7);
        chk("t4_flag_sticky", {tmo_a, tmo_b}, 2'b11);

        // T5: reset during CACHE_CLK
        pulse_edge();
        repeat (3) tick();
        chk("t5_in_cache", cclk_a, 1'b1);
        rst = 1'b1;
        sample_clk = 1'b1;
        tick();
        chk("t5_so", {so_a, so_b}, 128'h0);
        chk("t5_strobes", {lsb_a, crst_a, cclk_a, fd_a, busy_a}, 6'b0);
        chk("t5_status_a", {tmo_a, ovr_a, cyc_a}, 25'h0);
        chk("t5_status_b", {tmo_b, ovr_b, cyc_b}, 25'h0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy_a || busy_b) seen++;
        end
        chk("t5_no_start", seen, 0);
        sample_clk = 1'b0;
        tick();
        do_frame(na, nb);
        chk("t5_recover", {na[3:0], nb[3:0]}, 8'h11);
        chk("t5_recover_cyc", cyc_a, 16'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
